// File: rtl/ysyx_25030081_mdu.sv
// rtl/ysyx_25030081_mdu.sv - RV32M multiply/divide unit: 32-cycle shift-add multiplier and restoring divider
// Defining YSYX_25030081_MDU_FAST_MUL_EN swaps the iterative multiplier for a single-cycle 33x33 product.
module ysyx_25030081_mdu #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [2:0]            op,
   input  logic [DATA_WIDTH-1:0] op1,
   input  logic [DATA_WIDTH-1:0] op2,
   input  logic                  flush,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state;
   logic [5:0]  cnt;
   logic [2:0]  op_q;
   logic        neg1_q;
   logic        neg2_q;
   logic [63:0] prod;
   logic [63:0] mcand;
   logic [32:0] mplier;
   logic [31:0] rem_q;
   logic [31:0] quo_q;
   logic [31:0] divisor_q;

   logic        sgn1;
   logic        sgn2;
   logic        neg1;
   logic        neg2;
   logic [32:0] ext1;
   logic [32:0] ext2;
   logic [32:0] mag1;
   logic [32:0] mag2;
   logic [31:0] dmag1;
   logic [31:0] dmag2;
   logic        div_zero;
   logic        div_ovf;
   logic        bypass;
   logic [31:0] bypass_res;
   logic        accept;

   // Operands become magnitudes plus a sign flag; the sign is reapplied once at the end.
   always_comb begin
      sgn1       = op[2] ? ~op[0] : ((op[1:0] == 2'b01) || (op[1:0] == 2'b10));
      sgn2       = op[2] ? ~op[0] : (op[1:0] == 2'b01);
      neg1       = sgn1 & op1[31];
      neg2       = sgn2 & op2[31];
      ext1       = {neg1, op1};
      ext2       = {neg2, op2};
      mag1       = neg1 ? (33'd0 - ext1) : ext1;
      mag2       = neg2 ? (33'd0 - ext2) : ext2;
      dmag1      = neg1 ? (32'd0 - op1) : op1;
      dmag2      = neg2 ? (32'd0 - op2) : op2;
      div_zero   = (op2 == 32'd0);
      div_ovf    = ~op[0] & (op1 == 32'h8000_0000) & (op2 == 32'hFFFF_FFFF);
      bypass     = op[2] & (div_zero | div_ovf);
      if (div_zero)
         bypass_res = op[1] ? op1 : 32'hFFFF_FFFF;
      else
         bypass_res = op[1] ? 32'd0 : 32'h8000_0000;
      accept     = in_valid & in_ready & ~flush & (state == IDLE);
   end

`ifdef YSYX_25030081_MDU_FAST_MUL_EN
   logic [63:0] fast_prod;
   logic [31:0] fast_res;

   always_comb begin
      fast_prod = {{31{ext1[32]}}, ext1} * {{31{ext2[32]}}, ext2};
      fast_res  = (op[1:0] == 2'b00) ? fast_prod[31:0] : fast_prod[63:32];
   end
`endif

   logic [63:0] mul_next;
   logic [63:0] mul_fix;
   logic [31:0] mul_res;
   logic [32:0] div_shift;
   logic        div_ge;
   logic [31:0] rem_next;
   logic [31:0] quo_next;
   logic [31:0] quo_fix;
   logic [31:0] rem_fix;
   logic [31:0] div_res;

   // One iteration step; the final-step values feed the result so DONE follows the 32nd step directly.
   always_comb begin
      mul_next  = mplier[0] ? (prod + mcand) : prod;
      mul_fix   = (neg1_q ^ neg2_q) ? (64'd0 - mul_next) : mul_next;
      mul_res   = (op_q[1:0] == 2'b00) ? mul_fix[31:0] : mul_fix[63:32];
      div_shift = {rem_q, quo_q[31]};
      div_ge    = (div_shift >= {1'b0, divisor_q});
      rem_next  = div_ge ? (div_shift[31:0] - divisor_q) : div_shift[31:0];
      quo_next  = {quo_q[30:0], div_ge};
      quo_fix   = (neg1_q ^ neg2_q) ? (32'd0 - quo_next) : quo_next;
      rem_fix   = neg1_q ? (32'd0 - rem_next) : rem_next;
      div_res   = op_q[1] ? rem_fix : quo_fix;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= 6'd0;
         op_q      <= 3'd0;
         neg1_q    <= 1'b0;
         neg2_q    <= 1'b0;
         prod      <= 64'd0;
         mcand     <= 64'd0;
         mplier    <= 33'd0;
         rem_q     <= 32'd0;
         quo_q     <= 32'd0;
         divisor_q <= 32'd0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  op_q      <= op;
                  neg1_q    <= neg1;
                  neg2_q    <= neg2;
                  cnt       <= 6'd0;
                  prod      <= 64'd0;
                  mcand     <= {31'd0, mag1};
                  mplier    <= mag2;
                  rem_q     <= 32'd0;
                  quo_q     <= dmag1;
                  divisor_q <= dmag2;
                  in_ready  <= 1'b0;
                  if (bypass) begin
                     state     <= DONE;
                     out       <= bypass_res;
                     out_valid <= 1'b1;
                  end
`ifdef YSYX_25030081_MDU_FAST_MUL_EN
                  else if (!op[2]) begin
                     state     <= DONE;
                     out       <= fast_res;
                     out_valid <= 1'b1;
                  end
`endif
                  else begin
                     state <= CALC;
                  end
               end
            end
            CALC: begin
               if (flush) begin
                  state    <= IDLE;
                  in_ready <= 1'b1;
               end else begin
                  cnt    <= cnt + 6'd1;
                  prod   <= mul_next;
                  mcand  <= {mcand[62:0], 1'b0};
                  mplier <= {1'b0, mplier[32:1]};
                  rem_q  <= rem_next;
                  quo_q  <= quo_next;
                  if (cnt == 6'd31) begin
                     state     <= DONE;
                     out       <= op_q[2] ? div_res : mul_res;
                     out_valid <= 1'b1;
                  end
               end
            end
            DONE: begin
               if (flush || out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
            end
         endcase
      end
   end

endmodule
